parking_lane_monitor: RTL and testbench

Multi-lane successor to the single-entrance car-direction FSM. It monitors LANES independent gates, each with an outer sensor a and an inner sensor b. For each gate it recognises a full enter sequence (a, ab, b, none) or a full exit sequence (b, ab, a, none) and emits a one-cycle event pulse. It also keeps a saturating lot-occupancy count with full/empty flags, and sits between the debouncer bank and the display/barrier logic.

---
 rtl/parking_lane_monitor.sv | 180 ++++++++++++++++++
 tb/tb_parking_lane_monitor.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_lane_monitor.sv
// Per-lane enter/exit sequence recogniser with a shared saturating occupancy count.
// Define PARK_TIMEOUT_EN to build per-lane stall timers that abort hung sequences.
module parking_lane_monitor #(
    parameter int unsigned LANES   = 2,
    parameter int unsigned CAP     = 200,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic [LANES-1:0] sens_a_i,
    input  logic [LANES-1:0] sens_b_i,
    output logic [LANES-1:0] enter_o,
    output logic [LANES-1:0] exit_o,
    output logic [LANES-1:0] timeout_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int SumW = CNT_W + 2;

    typedef enum logic [2:0] {StIdle, StE1, StE2, StE3, StX1, StX2, StX3} state_e;

    state_e                  state_q [LANES];
    state_e                  state_d [LANES];
    logic [LANES-1:0][1:0]   ab;
    logic [LANES-1:0]        stall_hit;
    logic [LANES-1:0]        enter_d, enter_q;
    logic [LANES-1:0]        exit_d, exit_q;
    logic [LANES-1:0]        timeout_d, timeout_q;
    logic [CNT_W-1:0]        count_d, count_q;
    logic                    full_d, full_q;
    logic                    empty_d, empty_q;
    logic signed [SumW-1:0]  delta;
    logic signed [SumW-1:0]  sum;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            ab[i] = {sens_a_i[i], sens_b_i[i]};
        end
    end

`ifdef PARK_TIMEOUT_EN
    localparam int unsigned TmrW = $clog2(TIMEOUT + 1);

    logic [TmrW-1:0] tmr_q [LANES];
    logic [TmrW-1:0] tmr_d [LANES];

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            stall_hit[i] = (state_q[i] != StIdle) && (tmr_q[i] == TmrW'(TIMEOUT));
        end
    end

    // Timer runs only while a lane sits in one non-idle state.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            if ((state_d[i] != state_q[i]) || (state_d[i] == StIdle)) begin
                tmr_d[i] = '0;
            end else begin
                tmr_d[i] = tmr_q[i] + TmrW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < LANES; i++) begin
            if (!reset_ni) begin
                tmr_q[i] <= '0;
            end else begin
                tmr_q[i] <= tmr_d[i];
            end
        end
    end
`else
    assign stall_hit = '0;
`endif

    // Next-state logic; X states mirror E states with a and b swapped.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            state_d[i] = state_q[i];
            unique case (state_q[i])
                StIdle: begin
                    if (ab[i] == 2'b10)      state_d[i] = StE1;
                    else if (ab[i] == 2'b01) state_d[i] = StX1;
                end
                StE1: begin
                    if (ab[i] == 2'b11)      state_d[i] = StE2;
                    else if (ab[i] != 2'b10) state_d[i] = StIdle;
                end
                StE2: begin
                    if (ab[i] == 2'b01)      state_d[i] = StE3;
                    else if (ab[i] == 2'b10) state_d[i] = StE1;
                    else if (ab[i] == 2'b00) state_d[i] = StIdle;
                end
                StE3: begin
                    if (ab[i] == 2'b11)      state_d[i] = StE2;
                    else if (ab[i] != 2'b01) state_d[i] = StIdle;
                end
                StX1: begin
                    if (ab[i] == 2'b11)      state_d[i] = StX2;
                    else if (ab[i] != 2'b01) state_d[i] = StIdle;
                end
                StX2: begin
                    if (ab[i] == 2'b10)      state_d[i] = StX3;
                    else if (ab[i] == 2'b01) state_d[i] = StX1;
                    else if (ab[i] == 2'b00) state_d[i] = StIdle;
                end
                StX3: begin
                    if (ab[i] == 2'b11)      state_d[i] = StX2;
                    else if (ab[i] != 2'b10) state_d[i] = StIdle;
                end
                default: state_d[i] = StIdle;
            endcase
            if (stall_hit[i]) begin
                state_d[i] = StIdle;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            enter_d[i]   = (state_q[i] == StE3) && (ab[i] == 2'b00) && !stall_hit[i];
            exit_d[i]    = (state_q[i] == StX3) && (ab[i] == 2'b00) && !stall_hit[i];
            timeout_d[i] = stall_hit[i];
        end
    end

    // Occupancy nets the registered pulses, then clamps to [0, CAP].
    always_comb begin
        delta = '0;
        for (int i = 0; i < LANES; i++) begin
            delta = delta + SumW'(enter_q[i]) - SumW'(exit_q[i]);
        end
        sum = $signed({2'b00, count_q}) + delta;
        if (sum < 0) begin
            count_d = '0;
        end else if (sum > $signed(SumW'(CAP))) begin
            count_d = CNT_W'(CAP);
        end else begin
            count_d = CNT_W'(sum);
        end
        full_d  = (count_d == CNT_W'(CAP));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            for (int i = 0; i < LANES; i++) begin
                state_q[i] <= StIdle;
            end
            enter_q   <= '0;
            exit_q    <= '0;
            timeout_q <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                state_q[i] <= state_d[i];
            end
            enter_q   <= enter_d;
            exit_q    <= exit_d;
            timeout_q <= timeout_d;
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
        end
    end

    assign enter_o   = enter_q;
    assign exit_o    = exit_q;
    assign timeout_o = timeout_q;
    assign count_o   = count_q;
    assign full_o    = full_q;
    assign empty_o   = empty_q;

endmodule

// File: tb/tb_parking_lane_monitor.sv
// Directed bench for parking_lane_monitor: a CAP=200 instance and a CAP=3 instance share stimulus.
// Timeout expectations follow PARK_TIMEOUT_EN.
module tb_parking_lane_monitor;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] sens_a = '0;
    logic [1:0] sens_b = '0;

    logic [1:0] enter, exit_p, tmo;
    logic [7:0] count;
    logic       full, empty;

    logic [1:0] s_enter, s_exit, s_tmo;
    logic [1:0] s_count;
    logic       s_full, s_empty;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    parking_lane_monitor #(.LANES(2), .CAP(200), .CNT_W(8), .TIMEOUT(10)) dut (
        .clk_i(clk), .reset_ni(reset_n), .sens_a_i(sens_a), .sens_b_i(sens_b),
        .enter_o(enter), .exit_o(exit_p), .timeout_o(tmo),
        .count_o(count), .full_o(full), .empty_o(empty)
    );

    parking_lane_monitor #(.LANES(2), .CAP(3), .CNT_W(2), .TIMEOUT(10)) dut_sat (
        .clk_i(clk), .reset_ni(reset_n), .sens_a_i(sens_a), .sens_b_i(sens_b),
        .enter_o(s_enter), .exit_o(s_exit), .timeout_o(s_tmo),
        .count_o(s_count), .full_o(s_full), .empty_o(s_empty)
    );

    task automatic tick(input logic [1:0] a, input logic [1:0] b);
        sens_a = a;
        sens_b = b;
        @(posedge clk);
        #1;
    endtask

    // Drives a full entry on lanes in en and a full exit on lanes in ex, in lock step.
    task automatic do_seq(input logic [1:0] en, input logic [1:0] ex);
        tick(en, ex);
        tick(en | ex, en | ex);
        tick(ex, en);
        tick(2'b00, 2'b00);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(2'b00, 2'b00);
        tick(2'b00, 2'b00);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (count !== 8'd0) begin
            $display("FAIL reset_count: got %0d want 0", count); n_fail++;
        end
        n_cmp++;
        if ({empty, full} !== 2'b10) begin
            $display("FAIL reset_flags: got empty=%b full=%b want 1 0", empty, full); n_fail++;
        end
        n_cmp++;
        if ({enter, exit_p, tmo} !== 6'b0) begin
            $display("FAIL reset_pulses: got %b want 000000", {enter, exit_p, tmo}); n_fail++;
        end
    endtask

    task automatic test_enter();
        tick(2'b01, 2'b00);
        tick(2'b01, 2'b01);
        tick(2'b00, 2'b01);
        tick(2'b00, 2'b00);
        n_cmp++;
        if (enter !== 2'b01 || count !== 8'd0) begin
            $display("FAIL enter_pulse: got enter=%b count=%0d want 01 0", enter, count); n_fail++;
        end
        tick(2'b00, 2'b00);
        n_cmp++;
        if (enter !== 2'b00 || count !== 8'd1 || empty !== 1'b0) begin
            $display("FAIL enter_count: got enter=%b count=%0d empty=%b want 00 1 0",
                     enter, count, empty); n_fail++;
        end
    endtask

    task automatic test_back_out();
        logic [1:0] av [4];
        logic [1:0] bv [4];
        av = '{2'b10, 2'b10, 2'b10, 2'b00};
        bv = '{2'b00, 2'b10, 2'b00, 2'b00};
        for (int k = 0; k < 4; k++) begin
            tick(av[k], bv[k]);
            n_cmp++;
            if ({enter, exit_p} !== 4'b0) begin
                $display("FAIL back_out_pulse[%0d]: got %b want 0000", k, {enter, exit_p});
                n_fail++;
            end
        end
        tick(2'b00, 2'b00);
        n_cmp++;
        if (count !== 8'd1) begin
            $display("FAIL back_out_count: got %0d want 1", count); n_fail++;
        end
    endtask

    task automatic test_simultaneous();
        for (int k = 0; k < 4; k++) do_seq(2'b01, 2'b00);
        tick(2'b00, 2'b00);
        n_cmp++;
        if (count !== 8'd5) begin
            $display("FAIL simul_pre_count: got %0d want 5", count); n_fail++;
        end
        do_seq(2'b01, 2'b10);
        n_cmp++;
        if (enter !== 2'b01 || exit_p !== 2'b10) begin
            $display("FAIL simul_pulses: got enter=%b exit=%b want 01 10", enter, exit_p);
            n_fail++;
        end
        tick(2'b00, 2'b00);
        n_cmp++;
        if (count !== 8'd5) begin
            $display("FAIL simul_net_count: got %0d want 5", count); n_fail++;
        end
        do_seq(2'b11, 2'b00);
        n_cmp++;
        if (enter !== 2'b11) begin
            $display("FAIL dual_enter: got %b want 11", enter); n_fail++;
        end
        tick(2'b00, 2'b00);
        n_cmp++;
        if (count !== 8'd7) begin
            $display("FAIL dual_count: got %0d want 7", count); n_fail++;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        do_seq(2'b01, 2'b00);
        do_seq(2'b01, 2'b00);
        tick(2'b00, 2'b00);
        n_cmp++;
        if (count !== 8'd2) begin
            $display("FAIL mid_pre_count: got %0d want 2", count); n_fail++;
        end
        tick(2'b01, 2'b00);
        tick(2'b01, 2'b01);
        reset_n = 1'b0;
        tick(2'b01, 2'b01);
        reset_n = 1'b1;
        n_cmp++;
        if (count !== 8'd0 || empty !== 1'b1) begin
            $display("FAIL mid_reset_count: got count=%0d empty=%b want 0 1", count, empty);
            n_fail++;
        end
        tick(2'b00, 2'b01);
        tick(2'b00, 2'b00);
        n_cmp++;
        if (enter !== 2'b00) begin
            $display("FAIL mid_no_enter: got %b want 00", enter); n_fail++;
        end
        tick(2'b00, 2'b00);
        n_cmp++;
        if (count !== 8'd0 || empty !== 1'b1) begin
            $display("FAIL mid_post_count: got count=%0d empty=%b want 0 1", count, empty);
            n_fail++;
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            do_seq(2'b01, 2'b00);
            n_cmp++;
            if (s_enter !== 2'b01) begin
                $display("FAIL sat_enter[%0d]: got %b want 01", k, s_enter); n_fail++;
            end
            tick(2'b00, 2'b00);
            exp_cnt = (k < 3) ? 2'(k + 1) : 2'd3;
            n_cmp++;
            if (s_count !== exp_cnt) begin
                $display("FAIL sat_up_count[%0d]: got %0d want %0d", k, s_count, exp_cnt);
                n_fail++;
            end
        end
        n_cmp++;
        if ({s_full, s_empty} !== 2'b10) begin
            $display("FAIL sat_full: got full=%b empty=%b want 1 0", s_full, s_empty); n_fail++;
        end
        for (int k = 0; k < 4; k++) begin
            do_seq(2'b00, 2'b01);
            n_cmp++;
            if (s_exit !== 2'b01) begin
                $display("FAIL sat_exit[%0d]: got %b want 01", k, s_exit); n_fail++;
            end
            tick(2'b00, 2'b00);
            exp_cnt = (k < 3) ? 2'(2 - k) : 2'd0;
            n_cmp++;
            if (s_count !== exp_cnt) begin
                $display("FAIL sat_down_count[%0d]: got %0d want %0d", k, s_count, exp_cnt);
                n_fail++;
            end
        end
        n_cmp++;
        if ({s_full, s_empty} !== 2'b01) begin
            $display("FAIL sat_empty: got full=%b empty=%b want 0 1", s_full, s_empty);
            n_fail++;
        end
    endtask

    task automatic test_timeout();
        logic exp_to;
        logic [1:0] exp_enter;
        do_reset();
        tick(2'b01, 2'b00);
        for (int k = 1; k <= 11; k++) begin
            tick(2'b01, 2'b00);
`ifdef PARK_TIMEOUT_EN
            exp_to = (k == 11);
`else
            exp_to = 1'b0;
`endif
            n_cmp++;
            if (tmo[0] !== exp_to) begin
                $display("FAIL timeout_pulse[%0d]: got %b want %b", k, tmo[0], exp_to);
                n_fail++;
            end
        end
        tick(2'b01, 2'b01);
        tick(2'b00, 2'b01);
        tick(2'b00, 2'b00);
`ifdef PARK_TIMEOUT_EN
        exp_enter = 2'b00;
`else
        exp_enter = 2'b01;
`endif
        n_cmp++;
        if (enter !== exp_enter || tmo !== 2'b00) begin
            $display("FAIL timeout_after: got enter=%b timeout=%b want %b 00",
                     enter, tmo, exp_enter); n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_enter();
        test_back_out();
        test_simultaneous();
        test_reset_mid();
        test_saturation();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
